// File: rtl/decode_inst_queue_pkg.sv
// Shared fetch/decode types: instruction-queue entry layout, queue sizing
// and the branch predecode used by fetch to drive enq_is_branch.
package decode_inst_queue_pkg;

  typedef logic [31:0] virt_t;
  typedef logic [31:0] uint32_t;

  typedef struct packed {
    logic        valid;
    logic [4:0]  excode;
    logic        tlb_refill;
    logic        bd;
    logic [23:0] rsvd;
  } exception_t;

  typedef struct packed {
    virt_t      pc;
    uint32_t    inst;
    exception_t exception;
  } iq_entry_t;

  localparam int IQ_DEPTH       = 16;
  localparam int IQ_FETCH_WIDTH = 2;
  localparam int IQ_ISSUE_WIDTH = 2;
  localparam int IQ_ENTRY_W     = $bits(iq_entry_t);

  // True for MIPS32 branches/jumps that carry an architectural delay slot
  // (likely-branches are excluded: their slot is annulled, not paired).
  function automatic logic predecode_has_delay_slot(input uint32_t inst);
    logic [5:0] op;
    logic [5:0] funct;
    op    = inst[31:26];
    funct = inst[5:0];
    case (op)
      6'b000000: return (funct == 6'b001000) || (funct == 6'b001001);
      6'b000001: return inst[19:17] == 3'b000;
      6'b000010, 6'b000011, 6'b000100,
      6'b000101, 6'b000110, 6'b000111: return 1'b1;
      default:   return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/decode_inst_queue_issue_window.sv
// Issue window: limits issue to the entries present at the head and holds
// back a branch whose delay slot cannot issue in the same group.
module iq_issue_window
  import decode_inst_queue_pkg::*;
#(
  parameter int ISSUE_WIDTH     = IQ_ISSUE_WIDTH,
  parameter int OCC_W           = 5,
  parameter bit PAIR_DELAY_SLOT = 1'b1
) (
  input  logic [OCC_W-1:0]       i_occupancy,
  input  logic [ISSUE_WIDTH-1:0] i_is_branch,
  output logic [ISSUE_WIDTH-1:0] o_valid
);

  localparam int CW = $clog2(ISSUE_WIDTH + 1);

  logic [CW-1:0] w_avail;
  logic          w_stop;

  assign w_avail = (i_occupancy >= OCC_W'(ISSUE_WIDTH)) ? CW'(ISSUE_WIDTH)
                                                        : CW'(i_occupancy);

  // A branch is cut off together with everything after it, keeping the prefix.
  always_comb begin
    o_valid = '0;
    w_stop  = 1'b0;
    for (int i = 0; i < ISSUE_WIDTH; i++) begin
      if (!w_stop && (CW'(i) < w_avail)) begin
        if (PAIR_DELAY_SLOT && i_is_branch[i] && (CW'(i + 1) >= w_avail))
          w_stop = 1'b1;
        else
          o_valid[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/decode_inst_queue.sv
// Fetch-to-decode instruction queue: multi-lane circular buffer with
// in-order multi-issue and branch/delay-slot pairing.
module decode_inst_queue
  import decode_inst_queue_pkg::*;
#(
  parameter int DEPTH           = IQ_DEPTH,
  parameter int FETCH_WIDTH     = IQ_FETCH_WIDTH,
  parameter int ISSUE_WIDTH     = IQ_ISSUE_WIDTH,
  parameter int ENTRY_W         = IQ_ENTRY_W,
  parameter bit PAIR_DELAY_SLOT = 1'b1
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             flush,
  input  logic [FETCH_WIDTH-1:0]           enq_valid,
  input  logic [FETCH_WIDTH*ENTRY_W-1:0]   enq_data,
  input  logic [FETCH_WIDTH-1:0]           enq_is_branch,
  output logic                             enq_ready,
  output logic [ISSUE_WIDTH-1:0]           deq_valid,
  output logic [ISSUE_WIDTH*ENTRY_W-1:0]   deq_data,
  output logic [ISSUE_WIDTH-1:0]           deq_is_branch,
  input  logic [$clog2(ISSUE_WIDTH+1)-1:0] deq_accept,
  output logic [$clog2(DEPTH):0]           occupancy
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int NW = $clog2(FETCH_WIDTH + 1);

  // Pointers carry a wrap bit above the slot index.
  logic [PW-1:0]      r_head;
  logic [PW-1:0]      r_tail;
  logic [ENTRY_W-1:0] r_mem [DEPTH];
  logic [DEPTH-1:0]   r_br;

  logic [PW-1:0]              w_occ;
  logic [PW:0]                w_free;
  logic [NW-1:0]              w_enq_n;
  logic                       w_enq_fire;
  logic [ISSUE_WIDTH*ENTRY_W-1:0] w_rd_data;
  logic [ISSUE_WIDTH-1:0]     w_rd_br;

  assign w_occ      = r_tail - r_head;
  assign w_free     = (PW+1)'(DEPTH) - {1'b0, w_occ};
  // Readiness ignores space freed by this cycle's dequeue to stay off the decode path.
  assign enq_ready  = w_free >= (PW+1)'(FETCH_WIDTH);
  assign w_enq_fire = enq_ready && enq_valid[0] && !flush;
  assign occupancy  = w_occ;

  always_comb begin
    w_enq_n = '0;
    for (int i = 0; i < FETCH_WIDTH; i++)
      w_enq_n = w_enq_n + NW'(enq_valid[i]);
  end

  // ---- write side: lanes land at tail+i modulo DEPTH ----
  always_ff @(posedge clk) begin
    if (w_enq_fire) begin
      for (int i = 0; i < FETCH_WIDTH; i++) begin
        if (enq_valid[i]) begin
          r_mem[AW'(r_tail + PW'(i))] <= enq_data[i*ENTRY_W +: ENTRY_W];
          r_br[AW'(r_tail + PW'(i))]  <= enq_is_branch[i];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_head <= '0;
      r_tail <= '0;
    end else begin
      r_head <= r_head + PW'(deq_accept);
      if (w_enq_fire)
        r_tail <= r_tail + PW'(w_enq_n);
    end
  end

  // ---- read side: head..head+ISSUE_WIDTH-1, straddling the wrap per lane ----
  always_comb begin
    w_rd_data = '0;
    w_rd_br   = '0;
    for (int i = 0; i < ISSUE_WIDTH; i++) begin
      w_rd_data[i*ENTRY_W +: ENTRY_W] = r_mem[AW'(r_head + PW'(i))];
      w_rd_br[i]                      = r_br[AW'(r_head + PW'(i))];
    end
  end

  assign deq_data      = w_rd_data;
  assign deq_is_branch = w_rd_br;

  iq_issue_window #(
    .ISSUE_WIDTH     (ISSUE_WIDTH),
    .OCC_W           (PW),
    .PAIR_DELAY_SLOT (PAIR_DELAY_SLOT)
  ) u_window (
    .i_occupancy (w_occ),
    .i_is_branch (w_rd_br),
    .o_valid     (deq_valid)
  );

endmodule

// File: tb/tb_decode_inst_queue.sv
// Scoreboarded bench for decode_inst_queue: directed scenarios followed by
// randomized traffic, checked against a queue-level reference model.
module tb_decode_inst_queue;
  import decode_inst_queue_pkg::*;

  localparam int DEPTH = 8;
  localparam int FW    = 2;
  localparam int IW    = 2;
  localparam int EW    = IQ_ENTRY_W;
  localparam bit PAIR  = 1'b1;
  localparam int OW    = $clog2(DEPTH) + 1;
  localparam int ACW   = $clog2(IW + 1);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset, flush;
  logic [FW-1:0]    enq_valid, enq_is_branch;
  logic [FW*EW-1:0] enq_data;
  logic             enq_ready;
  logic [IW-1:0]    deq_valid, deq_is_branch;
  logic [IW*EW-1:0] deq_data;
  logic [ACW-1:0]   deq_accept;
  logic [OW-1:0]    occupancy;

  logic             np_flush;
  logic [FW-1:0]    np_enq_valid, np_enq_is_branch;
  logic [FW*EW-1:0] np_enq_data;
  logic             np_enq_ready;
  logic [IW-1:0]    np_deq_valid, np_deq_is_branch;
  logic [IW*EW-1:0] np_deq_data;
  logic [ACW-1:0]   np_deq_accept;
  logic [OW-1:0]    np_occupancy;

  decode_inst_queue #(
    .DEPTH(DEPTH), .FETCH_WIDTH(FW), .ISSUE_WIDTH(IW), .ENTRY_W(EW), .PAIR_DELAY_SLOT(PAIR)
  ) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .enq_valid(enq_valid), .enq_data(enq_data), .enq_is_branch(enq_is_branch),
    .enq_ready(enq_ready), .deq_valid(deq_valid), .deq_data(deq_data),
    .deq_is_branch(deq_is_branch), .deq_accept(deq_accept), .occupancy(occupancy)
  );

  decode_inst_queue #(
    .DEPTH(DEPTH), .FETCH_WIDTH(FW), .ISSUE_WIDTH(IW), .ENTRY_W(EW), .PAIR_DELAY_SLOT(1'b0)
  ) u_np (
    .clk(clk), .reset(reset), .flush(np_flush),
    .enq_valid(np_enq_valid), .enq_data(np_enq_data), .enq_is_branch(np_enq_is_branch),
    .enq_ready(np_enq_ready), .deq_valid(np_deq_valid), .deq_data(np_deq_data),
    .deq_is_branch(np_deq_is_branch), .deq_accept(np_deq_accept), .occupancy(np_occupancy)
  );

  typedef struct {
    logic [EW-1:0] d;
    logic          br;
  } ent_t;

  ent_t          exp_q[$];
  ent_t          mon_e;
  logic [IW-1:0] exp_valid;
  int            exp_occ;
  bit            exp_ready;
  bit            mon_en = 1'b0;
  int            errors = 0;
  int            checks = 0;
  int unsigned   pcn = 0;

  task automatic check(input string nm, input logic [EW-1:0] act, input logic [EW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [EW-1:0] mk();
    pcn = pcn + 1;
    return {32'(pcn << 2), 32'($urandom), 32'($urandom)};
  endfunction

  // One clock of stimulus. Expected outputs for this cycle come from the model
  // queue as it stands at cycle start; the model is then updated with the
  // entries the queue should accept.
  task automatic cycle(input logic [FW-1:0] ev, input logic [FW-1:0] br,
                       input logic [EW-1:0] d0, input logic [EW-1:0] d1,
                       input int acc, input bit fl, output bit took);
    int   sz;
    int   cnt;
    ent_t e;
    @(posedge clk);
    #1;
    sz  = exp_q.size();
    cnt = (sz < IW) ? sz : IW;
    // A group must never end on a branch: its delay slot would be left behind.
    if (PAIR && cnt > 0 && exp_q[cnt-1].br) cnt--;
    exp_occ   = sz;
    exp_ready = (DEPTH - sz) >= FW;
    exp_valid = IW'((1 << cnt) - 1);
    enq_valid     = ev;
    enq_is_branch = br;
    enq_data      = {d1, d0};
    flush         = fl;
    deq_accept    = ACW'((acc > cnt) ? cnt : acc);
    took = 1'b0;
    if (fl) begin
      exp_q.delete();
    end else if (exp_ready && ev[0]) begin
      took = 1'b1;
      e.d = d0; e.br = br[0];
      exp_q.push_back(e);
      if (ev[1]) begin
        e.d = d1; e.br = br[1];
        exp_q.push_back(e);
      end
    end
  endtask

  // Monitor: status against the model, issued entries against the scoreboard.
  always @(negedge clk) begin
    if (mon_en) begin
      check("occupancy", EW'(occupancy), EW'(exp_occ));
      check("enq_ready", EW'(enq_ready), EW'(exp_ready));
      check("deq_valid", EW'(deq_valid), EW'(exp_valid));
      checks++;
      assert (int'(deq_accept) <= $countones(deq_valid)) else begin
        errors++;
        $display("FAIL deq_accept_legal: accept %0d with deq_valid %b", deq_accept, deq_valid);
      end
      checks++;
      assert (!(enq_valid[1] && !enq_valid[0])) else begin
        errors++;
        $display("FAIL enq_valid_prefix: got %b", enq_valid);
      end
      if (!flush) begin
        for (int i = 0; i < int'(deq_accept); i++) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL deq_underflow: lane %0d issued with no expected entry", i);
          end else begin
            mon_e = exp_q.pop_front();
            check("deq_data", deq_data[i*EW +: EW], mon_e.d);
            check("deq_is_branch", EW'(deq_is_branch[i]), EW'(mon_e.br));
          end
        end
      end
    end
  end

  initial begin
    bit            took, fl, pend;
    int            acc, accp, r;
    logic [FW-1:0] pev, pbr;
    logic [EW-1:0] pd0, pd1, npd;

    reset = 1'b1; flush = 1'b0; enq_valid = '0; enq_is_branch = '0; enq_data = '0;
    deq_accept = '0;
    np_flush = 1'b0; np_enq_valid = '0; np_enq_is_branch = '0; np_enq_data = '0;
    np_deq_accept = '0;
    exp_valid = '0; exp_occ = 0; exp_ready = 1'b1;
    pend = 1'b0; pev = '0; pbr = '0; pd0 = '0; pd1 = '0;
    repeat (2) @(posedge clk);
    #1;
    reset  = 1'b0;
    mon_en = 1'b1;

    // fill to full, hold a group while stalled, then drain two per cycle
    repeat (4) cycle(2'b11, 2'b00, mk(), mk(), 0, 1'b0, took);
    cycle(2'b11, 2'b00, mk(), mk(), 0, 1'b0, took);
    repeat (4) cycle(2'b00, 2'b00, '0, '0, 2, 1'b0, took);
    cycle(2'b00, 2'b00, '0, '0, 0, 1'b0, took);

    // move pointers to slot 6, then straddle the wrap
    repeat (3) cycle(2'b11, 2'b00, mk(), mk(), 0, 1'b0, took);
    repeat (3) cycle(2'b00, 2'b00, '0, '0, 2, 1'b0, took);
    repeat (2) cycle(2'b11, 2'b00, mk(), mk(), 0, 1'b0, took);
    repeat (3) cycle(2'b00, 2'b00, '0, '0, 2, 1'b0, took);

    // [ALU, BEQ]: only ALU issues; once the slot arrives BEQ+slot issue together
    cycle(2'b11, 2'b10, mk(), mk(), 0, 1'b0, took);
    cycle(2'b01, 2'b00, mk(), mk(), 1, 1'b0, took);
    cycle(2'b00, 2'b00, '0, '0, 2, 1'b0, took);
    cycle(2'b00, 2'b00, '0, '0, 0, 1'b0, took);

    // lone branch: withheld with pairing, issued at once without
    cycle(2'b01, 2'b01, mk(), mk(), 0, 1'b0, took);
    npd = mk();
    np_enq_valid = 2'b01; np_enq_is_branch = 2'b01; np_enq_data = {EW'(0), npd};
    cycle(2'b00, 2'b00, '0, '0, 0, 1'b0, took);
    np_enq_valid = 2'b00;
    check("np_lone_valid", EW'(np_deq_valid), EW'(2'b01));
    check("np_lone_data", np_deq_data[0 +: EW], npd);
    check("np_lone_branch", EW'(np_deq_is_branch[0]), EW'(1'b1));
    np_deq_accept = 1;
    cycle(2'b01, 2'b00, mk(), mk(), 0, 1'b0, took);
    np_deq_accept = 0;
    check("np_occupancy_drained", EW'(np_occupancy), EW'(0));
    cycle(2'b00, 2'b00, '0, '0, 2, 1'b0, took);
    cycle(2'b00, 2'b00, '0, '0, 0, 1'b0, took);

    // flush at occupancy 5 with a concurrent enqueue and accept
    cycle(2'b11, 2'b00, mk(), mk(), 0, 1'b0, took);
    cycle(2'b11, 2'b00, mk(), mk(), 0, 1'b0, took);
    cycle(2'b01, 2'b00, mk(), mk(), 0, 1'b0, took);
    cycle(2'b11, 2'b00, mk(), mk(), 1, 1'b1, took);
    cycle(2'b00, 2'b00, '0, '0, 0, 1'b0, took);

    // threshold: occupancy 6 enq+deq accepted; occupancy 7 stalls enqueue
    repeat (3) cycle(2'b11, 2'b00, mk(), mk(), 0, 1'b0, took);
    cycle(2'b11, 2'b00, mk(), mk(), 2, 1'b0, took);
    cycle(2'b01, 2'b00, mk(), mk(), 0, 1'b0, took);
    cycle(2'b11, 2'b00, mk(), mk(), 2, 1'b0, took);
    cycle(2'b00, 2'b00, '0, '0, 0, 1'b0, took);
    cycle(2'b00, 2'b00, '0, '0, 0, 1'b1, took);
    cycle(2'b00, 2'b00, '0, '0, 0, 1'b0, took);

    // randomized traffic: fill-biased, balanced, then drain-biased
    for (int c = 0; c < 3000; c++) begin
      accp = (c < 1000) ? 30 : ((c < 2000) ? 70 : 95);
      if (!pend) begin
        r   = $urandom_range(0, 9);
        pev = (r < 3) ? 2'b00 : ((r < 6) ? 2'b01 : 2'b11);
        pbr = {($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0)};
        pd0 = mk();
        pd1 = mk();
        pend = (pev != 2'b00);
      end
      fl  = ($urandom_range(0, 59) == 0);
      acc = ($urandom_range(0, 99) < accp) ? $urandom_range(1, 2) : 0;
      cycle(pev, pbr, pd0, pd1, acc, fl, took);
      if (took || fl) pend = 1'b0;
    end
    repeat (12) cycle(2'b00, 2'b00, '0, '0, 2, 1'b0, took);

    @(negedge clk);
    #1;
    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
